// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Requester ids select which busy state a grant leads to.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arbState_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  // Fetches always read the whole word; sliced down to the real byte-enable width.
  localparam int MAX_BE_W = 16;
  localparam logic [MAX_BE_W-1:0] FETCH_BE_ALL = '1;

  function automatic arbState_e busyStateFor(input logic reqId);
    return (reqId == REQ_D) ? BUSY_D : BUSY_I;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Counts busy cycles without an ack; expired marks the last cycle before abort.
// A TIMEOUT of zero disables expiry entirely.
module mem_arb_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  logic [CW-1:0] count;

  assign expired = (TIMEOUT != 0) && enable && (count == LAST);

  // Hold at the last value on expiry; the owner clears us once it returns to idle.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the data stage.
// Data has priority, bounded by a streak limit so a waiting fetch cannot starve.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_done,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_done,
  output logic [DW-1:0]   d_rdata,
  output logic            stall_if,
  output logic            stall_d,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  output logic            err
);

  localparam int BW = DW / 8;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  arbState_e  state, nextState;
  logic [3:0] streak, streakNext;
  logic       effIfReq, effDReq;
  logic       grantI, grantD, finishI, finishD;
  logic       busy, timedOut;

  // A requester seeing its own done pulse is still holding req; that cycle does not count.
  assign effIfReq = if_req & ~if_done;
  assign effDReq  = d_req & ~d_done;
  assign busy     = (state != IDLE);

  assign stall_if = if_req & ~if_done;
  assign stall_d  = d_req & ~d_done;

  mem_arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) ackTimer (
    .clk    (clk),
    .reset  (reset),
    .clear  (~busy),
    .enable (busy & ~mem_ack),
    .expired(timedOut)
  );

  always_comb begin
    nextState  = state;
    grantI     = 1'b0;
    grantD     = 1'b0;
    finishI    = 1'b0;
    finishD    = 1'b0;
    streakNext = streak;
    case (state)
      IDLE: begin
        if (effDReq && !(effIfReq && streak == STREAK_MAX)) begin
          grantD    = 1'b1;
          nextState = busyStateFor(REQ_D);
        end else if (effIfReq) begin
          grantI    = 1'b1;
          nextState = busyStateFor(REQ_I);
        end
      end
      BUSY_I: begin
        if (mem_ack || timedOut) begin
          finishI   = 1'b1;
          nextState = IDLE;
        end
      end
      BUSY_D: begin
        if (mem_ack || timedOut) begin
          finishD   = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
    if (!if_req || grantI) begin
      streakNext = '0;
    end else if (grantD && streak != STREAK_MAX) begin
      streakNext = streak + 4'd1;
    end
  end

  // Bus registers only move on a grant or a finish, so they stay stable while busy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      streak    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      err       <= 1'b0;
    end else begin
      state   <= nextState;
      streak  <= streakNext;
      if_done <= finishI;
      d_done  <= finishD;
      if (grantD) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_be    <= d_be;
      end else if (grantI) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_be    <= FETCH_BE_ALL[BW-1:0];
      end else if (finishI || finishD) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
      if (finishI) begin
        if_rdata <= mem_ack ? mem_rdata : '0;
      end
      if (finishD) begin
        d_rdata <= mem_ack ? mem_rdata : '0;
      end
      if (timedOut) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level model.
// The model tracks who owns the memory and what each requester should see.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXS = 4;
  localparam int TMO  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_done, d_req, d_we, d_done;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic [BW-1:0] d_be, mem_be;
  logic          stall_if, stall_d, mem_req, mem_we, mem_ack, err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MAX_D_STREAK(MAXS), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_done(d_done), .d_rdata(d_rdata),
    .stall_if(stall_if), .stall_d(stall_d),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: owner 0 = nobody, 1 = fetch, 2 = data.
  int            mOwner = 0, mWait = 0, mStreak = 0, lastGrant = 0;
  logic          mReq = 0, mWe = 0, mIfDone = 0, mDDone = 0, mErr = 0;
  logic [AW-1:0] mAddr = '0;
  logic [DW-1:0] mWdata = '0, mIfRdata = '0, mDRdata = '0;
  logic [BW-1:0] mBe = '0;

  int   memDelay = 0;
  logic strayAck = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelUpdate();
    logic effI, effD, newIfDone, newDDone;
    logic [DW-1:0] rd;
    lastGrant = 0;
    if (!reset) begin
      mOwner = 0; mWait = 0; mStreak = 0; mReq = 0; mWe = 0; mAddr = '0; mWdata = '0;
      mBe = '0; mIfDone = 0; mDDone = 0; mErr = 0; mIfRdata = '0; mDRdata = '0;
      return;
    end
    effI = if_req && !mIfDone;
    effD = d_req && !mDDone;
    newIfDone = 0;
    newDDone  = 0;
    if (mOwner != 0) begin
      if (mem_ack || (mWait + 1 == TMO)) begin
        rd = mem_ack ? mem_rdata : '0;
        if (!mem_ack) mErr = 1;
        if (mOwner == 1) begin newIfDone = 1; mIfRdata = rd; end
        else begin newDDone = 1; mDRdata = rd; end
        mOwner = 0; mReq = 0; mWe = 0;
      end else begin
        mWait++;
      end
    end else if (effD && !(effI && mStreak == MAXS)) begin
      mOwner = 2; mReq = 1; mWe = d_we; mAddr = d_addr; mWdata = d_wdata; mBe = d_be;
      mWait = 0; lastGrant = 2;
      if (if_req && mStreak < MAXS) mStreak++;
    end else if (effI) begin
      mOwner = 1; mReq = 1; mWe = 0; mAddr = if_addr; mWdata = '0; mBe = '1;
      mWait = 0; lastGrant = 1; mStreak = 0;
    end
    if (!if_req) mStreak = 0;
    mIfDone = newIfDone;
    mDDone  = newDDone;
  endtask

  // One clock: memory responds, stalls checked, edge taken, registered outputs checked.
  task automatic applyStimulus();
    mem_ack = (mOwner != 0) ? (mWait == memDelay) : strayAck;
    #1;
    checkOutput("stall_if", stall_if, if_req & ~mIfDone);
    checkOutput("stall_d", stall_d, d_req & ~mDDone);
    @(posedge clk);
    #1;
    modelUpdate();
    checkOutput("mem_req", mem_req, mReq);
    checkOutput("mem_we", mem_we, mWe);
    checkOutput("mem_addr", mem_addr, mAddr);
    checkOutput("mem_wdata", mem_wdata, mWdata);
    checkOutput("mem_be", mem_be, mBe);
    checkOutput("if_done", if_done, mIfDone);
    checkOutput("d_done", d_done, mDDone);
    checkOutput("err", err, mErr);
    if (mIfDone) checkOutput("if_rdata", if_rdata, mIfRdata);
    if (mDDone) checkOutput("d_rdata", d_rdata, mDRdata);
  endtask

  task automatic idleCycles(input int n);
    if_req = 0; d_req = 0; d_we = 0;
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  initial begin
    int cyc, dDoneCycle, ifDoneCycle, obsD, obsI, reqCycles;
    logic prevReq, gotDone, ifHold, dHold;

    reset = 0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; d_be = '0; mem_ack = 0; mem_rdata = '0;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_if_rdata", if_rdata, 0);
    checkOutput("rst_d_rdata", d_rdata, 0);
    checkOutput("rst_err", err, 0);
    reset = 1;
    idleCycles(2);

    // Lone fetch against a zero-wait memory.
    if_req = 1; if_addr = 32'h100; memDelay = 0; mem_rdata = 32'h00500093;
    applyStimulus();
    checkOutput("t1_mem_req_on", mem_req, 1);
    checkOutput("t1_mem_addr", mem_addr, 32'h100);
    applyStimulus();
    checkOutput("t1_if_done", if_done, 1);
    checkOutput("t1_if_rdata", if_rdata, 32'h00500093);
    checkOutput("t1_mem_req_off", mem_req, 0);
    checkOutput("t1_stall_if_done", stall_if, 0);
    if_req = 0;
    applyStimulus();
    checkOutput("t1_done_single", if_done, 0);
    idleCycles(1);

    // Fetch and load together with two wait states: data first, then fetch.
    if_req = 1; if_addr = 32'h104; d_req = 1; d_we = 0; d_addr = 32'h2000;
    memDelay = 2; mem_rdata = 32'h11112222;
    cyc = 0; dDoneCycle = -1; ifDoneCycle = -1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus();
      cyc++;
      if (d_done && dDoneCycle < 0) dDoneCycle = cyc;
      if (if_done && ifDoneCycle < 0) ifDoneCycle = cyc;
      if (mDDone) begin d_req = 0; mem_rdata = 32'h33334444; end
      if (mIfDone) if_req = 0;
    end
    checkOutput("t2_d_done_cycle", dDoneCycle, 4);
    checkOutput("t2_if_done_cycle", ifDoneCycle, 8);
    idleCycles(1);

    // Continuous stores and fetches with a zero-wait memory.
    d_req = 1; d_we = 1; d_addr = 32'h4000; d_wdata = $urandom; d_be = 4'b0101;
    if_req = 1; if_addr = 32'h300; memDelay = 0; mem_rdata = 32'h0;
    prevReq = 0; obsD = 0; obsI = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus();
      if (mem_req && !prevReq) begin
        if (mem_we) obsD++;
        else obsI++;
      end
      prevReq = mem_req;
      if (mDDone) begin d_addr += 4; d_wdata = $urandom; d_be = ~d_be; end
      if (mIfDone) if_addr += 4;
    end
    checkOutput("t3_d_grants", obsD, 5);
    checkOutput("t3_i_grants", obsI, 5);
    idleCycles(2);

    // Slow store: bus must hold steady until the ack.
    d_req = 1; d_we = 1; d_addr = 32'h3000; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    memDelay = 5;
    applyStimulus();
    for (int k = 0; k < 6; k++) begin
      checkOutput("t4_addr_hold", mem_addr, 32'h3000);
      checkOutput("t4_wdata_hold", mem_wdata, 32'hDEADBEEF);
      checkOutput("t4_be_hold", mem_be, 4'b0011);
      applyStimulus();
    end
    checkOutput("t4_d_done", d_done, 1);
    idleCycles(1);

    // Memory never answers a fetch: abort, sticky error, then a normal load.
    if_req = 1; if_addr = 32'h200; memDelay = 1000;
    applyStimulus();
    reqCycles = 0;
    for (int i = 0; i < 20 && mem_req; i++) begin
      reqCycles++;
      applyStimulus();
    end
    checkOutput("t5_req_cycles", reqCycles, TMO);
    checkOutput("t5_if_done", if_done, 1);
    checkOutput("t5_if_rdata", if_rdata, 0);
    checkOutput("t5_err", err, 1);
    if_req = 0; d_req = 1; d_we = 0; d_addr = 32'h44; memDelay = 1; mem_rdata = 32'hCAFEF00D;
    gotDone = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      if (d_done) begin gotDone = 1; break; end
    end
    checkOutput("t5_load_done", gotDone, 1);
    checkOutput("t5_load_rdata", d_rdata, 32'hCAFEF00D);
    checkOutput("t5_err_sticky", err, 1);
    idleCycles(1);

    // Reset in the middle of a data transaction, then a stray ack.
    d_req = 1; d_we = 0; d_addr = 32'h50; memDelay = 1000;
    applyStimulus();
    applyStimulus();
    reset = 0;
    applyStimulus();
    checkOutput("t6_mem_req_drop", mem_req, 0);
    checkOutput("t6_no_done", d_done, 0);
    checkOutput("t6_err_clear", err, 0);
    reset = 1; d_req = 0; strayAck = 1;
    applyStimulus();
    applyStimulus();
    checkOutput("t6_stray_d", d_done, 0);
    checkOutput("t6_stray_if", if_done, 0);
    strayAck = 0;
    idleCycles(1);

    // Random traffic from requesters that hold their request until done.
    ifHold = 0; dHold = 0;
    for (int n = 0; n < 1500; n++) begin
      if (mIfDone) ifHold = 0;
      if (mDDone) dHold = 0;
      if (!ifHold) begin
        if_req = ($urandom_range(0, 2) != 0);
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!dHold) begin
        d_req = ($urandom_range(0, 2) != 0);
        d_we = $urandom_range(0, 1);
        d_addr = $urandom & 32'hFFFF_FFFC;
        d_wdata = $urandom;
        d_be = $urandom_range(0, 15);
      end
      ifHold = if_req;
      dHold = d_req;
      mem_rdata = $urandom;
      strayAck = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 199) != 0);
      applyStimulus();
      if (lastGrant != 0) memDelay = ($urandom_range(0, 19) == 0) ? 12 : $urandom_range(0, 3);
    end
    reset = 1; strayAck = 0;
    idleCycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
